// File: rtl/ad_cap_pkg.sv
// Shared types and constants for the AD9226 triggered capture sequencer.
package ad_cap_pkg;

    localparam int unsigned SMP_W   = 12;
    localparam int unsigned RAM_W   = 2 * SMP_W;
    localparam int unsigned DECIM_W = 8;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    localparam logic SRC_CH1 = 1'b0;
    localparam logic SRC_CH2 = 1'b1;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } cap_state_e;

endpackage

// File: rtl/ad_trig_detect.sv
// Level-crossing trigger detector: previous-sample register plus threshold compare.
module ad_trig_detect
    import ad_cap_pkg::*;
(
    input  logic             ad_clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             trig_edge,
    input  logic [SMP_W-1:0] cur,
    input  logic [SMP_W-1:0] level,
    output logic             trig_hit
);

    logic [SMP_W-1:0] prev_q;
    logic             prev_valid_q;
    logic             rise;
    logic             fall;

    // prev_valid follows enable by one cycle, so the first enabled cycle never fires.
    always_ff @(posedge ad_clk) begin
        if (rst) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            prev_q       <= cur;
            prev_valid_q <= enable;
        end
    end

    always_comb begin
        rise     = (prev_q < level) && (cur >= level);
        fall     = (prev_q > level) && (cur <= level);
        trig_hit = enable && prev_valid_q && ((trig_edge == EDGE_FALL) ? fall : rise);
    end

endmodule

// File: rtl/ad_capture_ctrl.sv
// Triggered, decimating capture of ch1/ch2 sample pairs into an external sample RAM.
module ad_capture_ctrl
    import ad_cap_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned AUTO_TRIG = 0,
    parameter int unsigned AUTO_W    = 24
) (
    input  logic               ad_clk,
    input  logic               rst,
    input  logic [SMP_W-1:0]   ad_ch1,
    input  logic [SMP_W-1:0]   ad_ch2,
    input  logic               arm,
    input  logic               abort,
    input  logic               trig_force,
    input  logic               trig_src,
    input  logic               trig_edge,
    input  logic [SMP_W-1:0]   trig_level,
    input  logic [DECIM_W-1:0] decim,
    input  logic [ADDR_W-1:0]  cap_len,
    output logic               ram_we,
    output logic [ADDR_W-1:0]  ram_waddr,
    output logic [RAM_W-1:0]   ram_wdata,
    output logic               busy,
    output logic               done,
    output logic               triggered_auto
);

    localparam logic [AUTO_W-1:0] AutoLast = AUTO_W'((AUTO_TRIG == 0) ? 0 : AUTO_TRIG - 1);

    cap_state_e state_q, state_d;

    logic               src_q;
    logic               edge_q;
    logic [SMP_W-1:0]   level_q;
    logic [DECIM_W-1:0] decim_q;
    logic [ADDR_W-1:0]  len_q;
    logic [AUTO_W-1:0]  tmo_q;
    logic [DECIM_W-1:0] dcnt_q;
    logic               auto_q;
    logic               ram_we_q;
    logic [ADDR_W-1:0]  ram_waddr_q;
    logic [RAM_W-1:0]   ram_wdata_q;

    logic              armed;
    logic              arm_ok;
    logic              trig_hit;
    logic              tmo_hit;
    logic              trig_fire;
    logic              cap_write;
    logic [ADDR_W-1:0] next_addr;

    assign armed     = (state_q == StArmed);
    assign arm_ok    = arm && !abort && (state_q == StIdle || state_q == StDone);
    assign tmo_hit   = (AUTO_TRIG != 0) && armed && (tmo_q == AutoLast);
    assign trig_fire = !abort && armed && (trig_force || trig_hit || tmo_hit);
    assign cap_write = !abort && (state_q == StCapture) && (dcnt_q == '0);
    assign next_addr = ram_waddr_q + 1'b1;

    ad_trig_detect u_trig_detect (
        .ad_clk    (ad_clk),
        .rst       (rst),
        .enable    (armed),
        .trig_edge (edge_q),
        .cur       ((src_q == SRC_CH2) ? ad_ch2 : ad_ch1),
        .level     (level_q),
        .trig_hit  (trig_hit)
    );

    always_ff @(posedge ad_clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: if (arm) state_d = StArmed;
                StArmed:        if (trig_fire) state_d = (len_q == '0) ? StDone : StCapture;
                StCapture:      if (cap_write && next_addr == len_q) state_d = StDone;
                default:        state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == StArmed) || (state_q == StCapture);
        done = (state_q == StDone);
    end

    always_ff @(posedge ad_clk) begin
        if (rst) begin
            src_q       <= 1'b0;
            edge_q      <= 1'b0;
            level_q     <= '0;
            decim_q     <= '0;
            len_q       <= '0;
            tmo_q       <= '0;
            dcnt_q      <= '0;
            auto_q      <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
        end else begin
            ram_we_q <= 1'b0;
            if (arm_ok) begin
                src_q   <= trig_src;
                edge_q  <= trig_edge;
                level_q <= trig_level;
                decim_q <= decim;
                len_q   <= cap_len;
                tmo_q   <= '0;
                auto_q  <= 1'b0;
            end else if (armed && !abort) begin
                tmo_q <= tmo_q + 1'b1;
            end

            if (trig_fire) begin
                ram_we_q    <= 1'b1;
                ram_waddr_q <= '0;
                ram_wdata_q <= {ad_ch2, ad_ch1};
                dcnt_q      <= decim_q;
                // Force outranks a coincident level hit; otherwise only the timeout is "auto".
                auto_q      <= trig_force || !trig_hit;
            end else if (cap_write) begin
                ram_we_q    <= 1'b1;
                ram_waddr_q <= next_addr;
                ram_wdata_q <= {ad_ch2, ad_ch1};
                dcnt_q      <= decim_q;
            end else if (state_q == StCapture && dcnt_q != '0) begin
                dcnt_q <= dcnt_q - 1'b1;
            end
        end
    end

    assign ram_we         = ram_we_q;
    assign ram_waddr      = ram_waddr_q;
    assign ram_wdata      = ram_wdata_q;
    assign triggered_auto = auto_q;

endmodule

// File: tb/tb_ad_capture_ctrl.sv
// Scoreboard bench for ad_capture_ctrl: stimulus pushes expected RAM writes, a monitor checks them.
module tb_ad_capture_ctrl;

    localparam int unsigned AW = 4;

    logic          ad_clk = 1'b0;
    logic          rst;
    logic [11:0]   ad_ch1, ad_ch2;
    logic          arm, abort, trig_force, trig_src, trig_edge;
    logic [11:0]   trig_level;
    logic [7:0]    decim;
    logic [AW-1:0] cap_len;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [23:0]   ram_wdata;
    logic          busy, done, triggered_auto;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [23:0]   data;
        logic          dn;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    ad_capture_ctrl #(
        .ADDR_W    (AW),
        .AUTO_TRIG (100),
        .AUTO_W    (24)
    ) dut (
        .ad_clk         (ad_clk),
        .rst            (rst),
        .ad_ch1         (ad_ch1),
        .ad_ch2         (ad_ch2),
        .arm            (arm),
        .abort          (abort),
        .trig_force     (trig_force),
        .trig_src       (trig_src),
        .trig_edge      (trig_edge),
        .trig_level     (trig_level),
        .decim          (decim),
        .cap_len        (cap_len),
        .ram_we         (ram_we),
        .ram_waddr      (ram_waddr),
        .ram_wdata      (ram_wdata),
        .busy           (busy),
        .done           (done),
        .triggered_auto (triggered_auto)
    );

    always #5 ad_clk = ~ad_clk;

    always @(posedge ad_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge ad_clk);
        #1;
    endtask

    task automatic push(input int c, input logic [AW-1:0] a, input logic [23:0] d, input logic dn);
        exp_t e;
        e.cyc  = c;
        e.addr = a;
        e.data = d;
        e.dn   = dn;
        sb.push_back(e);
    endtask

    task automatic do_arm(input logic src, input logic edg, input logic [11:0] lvl,
                          input logic [7:0] dec, input logic [AW-1:0] len);
        trig_src   = src;
        trig_edge  = edg;
        trig_level = lvl;
        decim      = dec;
        cap_len    = len;
        arm        = 1'b1;
        step();
        arm = 1'b0;
        check("armed_busy", busy, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, ram_we, 0);
        check({tag, "_waddr"}, ram_waddr, 0);
        check({tag, "_wdata"}, ram_wdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_tauto"}, triggered_auto, 0);
    endtask

    // Monitor: every visible write must match the head of the scoreboard.
    always @(negedge ad_clk) begin
        exp_t e;
        if (ram_we === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h want no write (cycle %0d)",
                         ram_waddr, ram_wdata, cyc);
            end else begin
                e = sb.pop_front();
                check("wr_cycle", cyc, e.cyc);
                check("wr_addr", ram_waddr, e.addr);
                check("wr_data", ram_wdata, e.data);
                check("wr_done", done, e.dn);
                check("wr_busy", busy, !e.dn);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0; trig_force = 1'b0;
        trig_src = 1'b0; trig_edge = 1'b0; trig_level = '0; decim = '0; cap_len = '0;
        ad_ch1 = '0; ad_ch2 = '0;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // Rising on ch1; later input changes and an arm during CAPTURE must be ignored.
        ad_ch1 = 12'h7E0;
        ad_ch2 = 12'h123;
        do_arm(1'b0, 1'b0, 12'h800, 8'd0, 4'd7);
        trig_src = 1'b1; trig_edge = 1'b1; trig_level = 12'h000; decim = 8'd5; cap_len = 4'd0;
        for (int i = 0; i < 14; i++) begin
            ad_ch1 = 12'h7F0 + 12'(8 * i);
            arm    = (i == 5);
            if (i >= 2 && i <= 9) push(cyc + 1, AW'(i - 2), {12'h123, ad_ch1}, i == 9);
            step();
        end
        arm = 1'b0;
        check("rise_done", done, 1);
        check("rise_busy", busy, 0);
        check("rise_tauto", triggered_auto, 0);
        check("rise_waddr_hold", ram_waddr, 7);

        // Forced trigger with decim=3: writes every 4 cycles.
        ad_ch2 = 12'h0F0;
        do_arm(1'b0, 1'b0, 12'hFFF, 8'd3, 4'd3);
        for (int i = 0; i < 16; i++) begin
            ad_ch1     = 12'h100 + 12'(i);
            trig_force = (i == 0);
            if (i % 4 == 0) push(cyc + 1, AW'(i / 4), {12'h0F0, ad_ch1}, i == 12);
            step();
        end
        trig_force = 1'b0;
        check("decim_tauto", triggered_auto, 1);
        check("decim_done", done, 1);

        // Falling crossing on ch2.
        ad_ch1 = 12'h0AA;
        ad_ch2 = 12'h500;
        do_arm(1'b1, 1'b1, 12'h400, 8'd0, 4'd1);
        check("arm_clears_done", done, 0);
        for (int i = 0; i < 7; i++) begin
            ad_ch2 = (i < 2) ? 12'h500 : 12'h400;
            if (i == 2 || i == 3) push(cyc + 1, AW'(i - 2), {12'h400, 12'h0AA}, i == 3);
            step();
        end
        check("fall_tauto", triggered_auto, 0);
        check("fall_done", done, 1);

        // Flat at the threshold from arm onwards: no crossing, so stay armed.
        do_arm(1'b1, 1'b1, 12'h400, 8'd0, 4'd1);
        repeat (20) step();
        check("flat_busy", busy, 1);
        check("flat_done", done, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("flat_abort_busy", busy, 0);
        check("flat_abort_done", done, 0);

        // Timeout: flat input, single write 100 cycles after the arm edge.
        ad_ch1 = 12'h200;
        ad_ch2 = 12'h300;
        do_arm(1'b0, 1'b0, 12'hFFF, 8'd0, 4'd0);
        push(cyc + 100, '0, {12'h300, 12'h200}, 1'b1);
        repeat (105) step();
        check("auto_tauto", triggered_auto, 1);
        check("auto_done", done, 1);

        // Abort together with arm while address 3 is on the bus.
        ad_ch2 = 12'h055;
        do_arm(1'b0, 1'b0, 12'hFFF, 8'd0, 4'd9);
        for (int i = 0; i < 10; i++) begin
            ad_ch1     = 12'h500 + 12'(i);
            trig_force = (i == 0);
            abort      = (i == 4);
            arm        = (i == 4);
            if (i < 4) push(cyc + 1, AW'(i), {12'h055, ad_ch1}, 1'b0);
            if (i == 4) check("abort_at_addr", ram_waddr, 3);
            step();
            if (i == 4) begin
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_we", ram_we, 0);
            end
        end
        check("abort_idle_busy", busy, 0);
        do_arm(1'b0, 1'b0, 12'hFFF, 8'd1, 4'd2);
        for (int i = 0; i < 8; i++) begin
            ad_ch1     = 12'h600 + 12'(i);
            trig_force = (i == 0);
            if (i % 2 == 0 && i <= 4) push(cyc + 1, AW'(i / 2), {12'h055, ad_ch1}, i == 4);
            step();
        end
        check("rearm_done", done, 1);

        // Reset in the middle of a decimated capture.
        do_arm(1'b0, 1'b0, 12'hFFF, 8'd2, 4'd15);
        for (int i = 0; i < 8; i++) begin
            ad_ch1     = 12'h700 + 12'(i);
            trig_force = (i == 0);
            rst        = (i == 7);
            if (i % 3 == 0) push(cyc + 1, AW'(i / 3), {12'h055, ad_ch1}, 1'b0);
            step();
        end
        check_all_zero("midrst");
        rst = 1'b0;

        // Full-depth capture after reset: addresses 0..15, no wrap.
        ad_ch2 = 12'hABC;
        do_arm(1'b0, 1'b0, 12'hFFF, 8'd0, 4'd15);
        for (int i = 0; i < 20; i++) begin
            ad_ch1     = 12'(i * 7);
            trig_force = (i == 0);
            if (i < 16) push(cyc + 1, AW'(i), {12'hABC, ad_ch1}, i == 15);
            step();
        end
        trig_force = 1'b0;
        check("fill_done", done, 1);
        check("fill_busy", busy, 0);
        check("fill_waddr", ram_waddr, 15);
        check("fill_tauto", triggered_auto, 1);

        repeat (3) step();
        check("pending_writes", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
